preta_patch_sched: RTL and testbench
====================================

Name: preta_patch_sched

Overview:
- Sequences the Winograd input-transform stage (4x4 patch -> B^T d B, 1-cycle registered latency).
- Walks a frame of tiles in order channel (innermost), tile column, tile row, and issues one patch fetch per tile/channel to the patch fetch unit.
- Forwards each returned patch to the transform as a single-cycle valid.
- Throttles issue with a credit counter owned by the downstream transform-output buffer, and signals frame completion after the last transformed patch emerges.

Parameters:
- TILE_W, default 8: width of the tile-row and tile-column counters and config fields.
- CH_W, default 10: width of the channel counter and config field.
- CREDITS, default 4: number of free downstream buffer slots at reset.
- CRED_W, default 3: credit counter width; must hold CREDITS.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle start pulse; sampled only in IDLE
- cfg_abort  in  1  abort the current frame
- cfg_tiles_h  in  TILE_W  tile rows in the frame
- cfg_tiles_w  in  TILE_W  tile columns in the frame
- cfg_channels  in  CH_W  input channels
- fetch_req  out  1  patch fetch request
- fetch_ty  out  TILE_W  tile row of the request
- fetch_tx  out  TILE_W  tile column of the request
- fetch_ch  out  CH_W  channel of the request
- fetch_gnt  in  1  fetch unit accepts the request
- fetch_rvalid  in  1  fetch unit is presenting patch data this cycle
- conv_valid_in  out  1  drives the transform's valid_in
- conv_valid_out  in  1  the transform's valid_out
- credit_ret  in  1  downstream buffer freed one slot
- credits  out  CRED_W  current credit count
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a frame completes
- credit_err  out  1  sticky: credit overflow occurred
- perf_stall_cycles  out  32  stall counter (see Optional Feature)

Behaviour:
- Reset values:
  - State IDLE; all counters 0.
  - fetch_req=0, fetch_ty=0, fetch_tx=0, fetch_ch=0, conv_valid_in=0.
  - credits=CREDITS, busy=0, done=0, credit_err=0, perf_stall_cycles=0.
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - On cfg_start, latch the three config fields and clear the ty/tx/ch counters.
  - If any config field is 0: stay in IDLE and pulse done on the next cycle.
  - Otherwise go to ISSUE.
- ISSUE:
  - fetch_req = (credits != 0). fetch_ty/tx/ch show the current counters and stay stable while fetch_req is held.
  - fetch_gnt counts only when fetch_req=1.
  - On an accepted grant: credits decrements and the state goes to WAIT.
- WAIT:
  - conv_valid_in = fetch_rvalid (combinational; patch data goes straight from the fetch unit into the transform).
  - On fetch_rvalid, advance the counters: ch++; on wrap ch=0 and tx++; on wrap tx=0 and ty++.
  - If the patch just forwarded was the last one (ty=H-1, tx=W-1, ch=C-1), go to DRAIN; otherwise go to ISSUE.
  - fetch_rvalid outside WAIT is ignored and does not drive conv_valid_in.
- DRAIN: wait for conv_valid_out (arrives the cycle after the last conv_valid_in), then pulse done and go to IDLE.
- Issue throughput: at most one patch per 2 cycles, since only one fetch is in flight.
- Credits:
  - credit_ret increments; an accepted grant decrements.
  - Both in the same cycle: credits unchanged.
  - credit_ret while credits==CREDITS and no grant: credits saturates and credit_err sets. credit_err clears only on reset.
- Abort:
  - cfg_abort in any non-IDLE state: next cycle the state is IDLE, fetch_req=0, no done pulse.
  - Counters are not cleared; they are reinitialised on the next cfg_start.
  - Credits are retained, because outstanding buffer slots still return.
  - Abort takes priority over every other transition in the same cycle.
- cfg_start while busy: ignored.
- Reset mid-frame: immediate return to the reset values above. Any in-flight fetch is the fetch unit's responsibility.

Optional Feature:
- Macro PRETA_SCHED_PERF_EN.
- Defined:
  - perf_stall_cycles is a 32-bit counter, cleared on an accepted cfg_start.
  - It increments each cycle in ISSUE with credits==0, or with fetch_req=1 and fetch_gnt=0.
  - It saturates at 0xFFFFFFFF.
- Not defined: perf_stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- H=1, W=2, C=2, credits never returned, fetch_gnt and fetch_rvalid always 1 → fetches (0,0,0), (0,0,1), (0,1,0), (0,1,1); 4 conv_valid_in pulses; credits 4→0; done one cycle after the final conv_valid_out.
- CREDITS=4, 6-patch frame, credit_ret held low → exactly 4 grants; fetch_req low with credits=0; one credit_ret → fifth fetch issues; perf_stall_cycles (PERF_EN) counts the stalled cycles.
- credit_ret asserted in the same cycle as a grant at credits=2 → credits stays 2; credit_ret at credits=4 → credits=4 and credit_err=1.
- cfg_abort in WAIT on patch 3 of 8 → IDLE next cycle; no done; a new cfg_start with H=W=C=1 → single fetch (0,0,0), then done.
- cfg_start with cfg_channels=0 → done pulse next cycle; fetch_req never asserted; busy stays 0.
- fetch_gnt held low for 5 cycles → fetch_req and its coordinates stable for all 5 cycles; a stray fetch_rvalid in ISSUE → conv_valid_in stays 0.

Source files
------------

// File: rtl/preta_patch_sched.sv
`default_nettype none
// ============================================================================
// Module   : preta_patch_sched
// Purpose  : Walks a frame of tiles (channel innermost, then column, then row)
//            and feeds patch fetches into the Winograd input transform under
//            downstream credit control.
//            Optional macro: PRETA_SCHED_PERF_EN (builds the stall counter).
// Revision : 1.0 - initial release
// ============================================================================
module preta_patch_sched #(
    parameter int TILE_W  = 8,
    parameter int CH_W    = 10,
    parameter int CREDITS = 4,
    parameter int CRED_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [TILE_W-1:0] cfg_tiles_h,
    input  logic [TILE_W-1:0] cfg_tiles_w,
    input  logic [CH_W-1:0]   cfg_channels,
    output logic              fetch_req,
    output logic [TILE_W-1:0] fetch_ty,
    output logic [TILE_W-1:0] fetch_tx,
    output logic [CH_W-1:0]   fetch_ch,
    input  logic              fetch_gnt,
    input  logic              fetch_rvalid,
    output logic              conv_valid_in,
    input  logic              conv_valid_out,
    input  logic              credit_ret,
    output logic [CRED_W-1:0] credits,
    output logic              busy,
    output logic              done,
    output logic              credit_err,
    output logic [31:0]       perf_stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [CRED_W-1:0] c_CRED_FULL = CRED_W'(CREDITS);
    localparam logic [TILE_W-1:0] c_T_ONE     = TILE_W'(1);
    localparam logic [CH_W-1:0]   c_C_ONE     = CH_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TILE_W-1:0] r_h;
    logic [TILE_W-1:0] r_w;
    logic [TILE_W-1:0] r_ty;
    logic [TILE_W-1:0] r_tx;
    logic [CH_W-1:0]   r_c;
    logic [CH_W-1:0]   r_ch;
    logic [CRED_W-1:0] r_credits;
    logic              r_credit_err;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_start;
    logic              w_cfg_zero;
    logic              w_grant;
    logic              w_fwd;
    logic              w_last_ch;
    logic              w_last_tx;
    logic              w_last_ty;

    assign w_start    = (r_state == S_IDLE) && cfg_start;
    assign w_cfg_zero = (cfg_tiles_h == '0) || (cfg_tiles_w == '0) || (cfg_channels == '0);
    assign fetch_req  = (r_state == S_ISSUE) && (r_credits != '0);
    assign w_grant    = fetch_req && fetch_gnt;
    // Patch data bypasses any register so the transform sees it the same cycle.
    assign w_fwd      = (r_state == S_WAIT) && fetch_rvalid;
    assign w_last_ch  = (r_ch == r_c - c_C_ONE);
    assign w_last_tx  = (r_tx == r_w - c_T_ONE);
    assign w_last_ty  = (r_ty == r_h - c_T_ONE);

    assign conv_valid_in = w_fwd;
    assign fetch_ty      = r_ty;
    assign fetch_tx      = r_tx;
    assign fetch_ch      = r_ch;
    assign credits       = r_credits;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign credit_err    = r_credit_err;

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        if ((r_state != S_IDLE) && cfg_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        if (w_cfg_zero) w_done_nxt  = 1'b1;
                        else            w_state_nxt = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_grant) w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (fetch_rvalid)
                        w_state_nxt = (w_last_ch && w_last_tx && w_last_ty) ? S_DRAIN : S_ISSUE;
                end
                S_DRAIN: begin
                    if (conv_valid_out) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h  <= '0;
            r_w  <= '0;
            r_c  <= '0;
            r_ty <= '0;
            r_tx <= '0;
            r_ch <= '0;
        end else if (w_start) begin
            r_h  <= cfg_tiles_h;
            r_w  <= cfg_tiles_w;
            r_c  <= cfg_channels;
            r_ty <= '0;
            r_tx <= '0;
            r_ch <= '0;
        end else if (w_fwd) begin
            if (!w_last_ch) begin
                r_ch <= r_ch + c_C_ONE;
            end else begin
                r_ch <= '0;
                if (!w_last_tx) begin
                    r_tx <= r_tx + c_T_ONE;
                end else begin
                    r_tx <= '0;
                    r_ty <= r_ty + c_T_ONE;
                end
            end
        end
    end

    // A return against a full counter means the buffer over-returned; hold and flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits    <= c_CRED_FULL;
            r_credit_err <= 1'b0;
        end else begin
            case ({w_grant, credit_ret})
                2'b10: r_credits <= r_credits - CRED_W'(1);
                2'b01: begin
                    if (r_credits == c_CRED_FULL) r_credit_err <= 1'b1;
                    else                          r_credits    <= r_credits + CRED_W'(1);
                end
                default: r_credits <= r_credits;
            endcase
        end
    end

`ifdef PRETA_SCHED_PERF_EN
    logic [31:0] r_perf;
    logic        w_stall;

    assign w_stall = (r_state == S_ISSUE) && ((r_credits == '0) || (fetch_req && !fetch_gnt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         r_perf <= '0;
        else if (w_start)                   r_perf <= '0;
        else if (w_stall && (r_perf != '1)) r_perf <= r_perf + 32'd1;
    end

    assign perf_stall_cycles = r_perf;
`else
    assign perf_stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_preta_patch_sched.sv
`default_nettype none
// Bench for preta_patch_sched: frame-level model plus directed scenarios.
module tb_preta_patch_sched;
    localparam int TILE_W = 8, CH_W = 10, CREDITS = 4, CRED_W = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_start, cfg_abort, fetch_gnt, credit_ret;
    logic [TILE_W-1:0] cfg_tiles_h, cfg_tiles_w;
    logic [CH_W-1:0]   cfg_channels;
    logic              fetch_req, conv_valid_in, busy, done, credit_err;
    logic [TILE_W-1:0] fetch_ty, fetch_tx;
    logic [CH_W-1:0]   fetch_ch;
    logic [CRED_W-1:0] credits;
    logic [31:0]       perf_stall_cycles;
    wire               fetch_rvalid;
    wire               conv_valid_out;

    always #5 clk = ~clk;

    preta_patch_sched #(.TILE_W(TILE_W), .CH_W(CH_W), .CREDITS(CREDITS), .CRED_W(CRED_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_tiles_h(cfg_tiles_h), .cfg_tiles_w(cfg_tiles_w), .cfg_channels(cfg_channels),
        .fetch_req(fetch_req), .fetch_ty(fetch_ty), .fetch_tx(fetch_tx), .fetch_ch(fetch_ch),
        .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid), .conv_valid_in(conv_valid_in),
        .conv_valid_out(conv_valid_out), .credit_ret(credit_ret), .credits(credits),
        .busy(busy), .done(done), .credit_err(credit_err), .perf_stall_cycles(perf_stall_cycles)
    );

    // Neighbours: fetch unit answering one cycle after a grant, 1-cycle transform.
    logic pend, cvo_r;
    bit   auto_rv, man_rv;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= 1'b0;
            cvo_r <= 1'b0;
        end else begin
            pend  <= fetch_req && fetch_gnt;
            cvo_r <= conv_valid_in;
        end
    end
    assign fetch_rvalid   = auto_rv ? pend : man_rv;
    assign conv_valid_out = cvo_r;

    int n_tests = 0, n_fail = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame model: list of patches still to fetch, one fetch in flight, credit pool.
    typedef struct packed {
        logic [TILE_W-1:0] ty;
        logic [TILE_W-1:0] tx;
        logic [CH_W-1:0]   ch;
    } coord_t;
    coord_t      q[$];
    coord_t      glog[$];
    bit          m_active, m_infl, m_err, m_done_exp;
    bit          e_req, e_grant, e_done_nxt, e_stall;
    int          m_credits;
    logic [31:0] m_perf;
    int          cnt_grant = 0, cnt_cvi = 0, cnt_done = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_active = 0; m_infl = 0; m_err = 0; m_done_exp = 0;
            m_credits = CREDITS; m_perf = 0;
        end else begin
            e_req = m_active && (q.size() > 0) && !m_infl && (m_credits != 0);
            chk("fetch_req", {31'd0, fetch_req}, {31'd0, e_req});
            if (e_req) begin
                chk("fetch_ty", {24'd0, fetch_ty}, {24'd0, q[0].ty});
                chk("fetch_tx", {24'd0, fetch_tx}, {24'd0, q[0].tx});
                chk("fetch_ch", {22'd0, fetch_ch}, {22'd0, q[0].ch});
            end
            chk("conv_valid_in", {31'd0, conv_valid_in}, {31'd0, (m_infl && fetch_rvalid)});
            chk("credits", {29'd0, credits}, m_credits);
            chk("busy", {31'd0, busy}, {31'd0, m_active});
            chk("done", {31'd0, done}, {31'd0, m_done_exp});
            chk("credit_err", {31'd0, credit_err}, {31'd0, m_err});
            chk("perf_stall_cycles", perf_stall_cycles, m_perf);
            if (conv_valid_in) cnt_cvi++;
            if (done) cnt_done++;

            e_grant    = e_req && fetch_gnt;
            e_done_nxt = 0;
            e_stall    = m_active && (q.size() > 0) && !m_infl && ((m_credits == 0) || !fetch_gnt);
`ifdef PRETA_SCHED_PERF_EN
            if (!m_active && cfg_start)           m_perf = 0;
            else if (e_stall && m_perf != '1)     m_perf = m_perf + 1;
`endif
            if (e_grant && !credit_ret) m_credits--;
            else if (credit_ret && !e_grant) begin
                if (m_credits == CREDITS) m_err = 1;
                else                      m_credits++;
            end

            if (m_active && cfg_abort) begin
                m_active = 0; m_infl = 0; q.delete();
            end else if (!m_active) begin
                if (cfg_start) begin
                    if (cfg_tiles_h == 0 || cfg_tiles_w == 0 || cfg_channels == 0) e_done_nxt = 1;
                    else begin
                        m_active = 1;
                        for (int y = 0; y < int'(cfg_tiles_h); y++)
                            for (int x = 0; x < int'(cfg_tiles_w); x++)
                                for (int c = 0; c < int'(cfg_channels); c++)
                                    q.push_back('{ty: TILE_W'(y), tx: TILE_W'(x), ch: CH_W'(c)});
                    end
                end
            end else begin
                if (q.size() == 0 && !m_infl && conv_valid_out) begin
                    m_active = 0; e_done_nxt = 1;
                end
                if (m_infl && fetch_rvalid) m_infl = 0;
                else if (e_grant) begin
                    glog.push_back(q.pop_front());
                    m_infl = 1;
                end
            end
            if (e_grant) cnt_grant++;
            m_done_exp = e_done_nxt;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cfg_start = 0; cfg_abort = 0; fetch_gnt = 0; credit_ret = 0;
        cfg_tiles_h = 0; cfg_tiles_w = 0; cfg_channels = 0;
        auto_rv = 0; man_rv = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start_frame(input int h, input int w, input int c);
        cfg_tiles_h = TILE_W'(h); cfg_tiles_w = TILE_W'(w); cfg_channels = CH_W'(c);
        cfg_start = 1; tick(); cfg_start = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = cnt_done;
        for (int i = 0; i < budget && cnt_done == d0; i++) tick();
        chk(name, cnt_done - d0, 1);
    endtask

    task automatic grant_one(input bit with_ret);
        for (int i = 0; i < 20 && !fetch_req; i++) tick();
        chk("grant_wait", {31'd0, fetch_req}, 1);
        fetch_gnt = 1; credit_ret = with_ret;
        tick();
        fetch_gnt = 0; credit_ret = 0;
    endtask

    initial begin
        int g0, c0, d0;
        // Reset values while reset is held
        rst_n = 0;
        cfg_start = 0; cfg_abort = 0; fetch_gnt = 0; credit_ret = 0;
        cfg_tiles_h = 0; cfg_tiles_w = 0; cfg_channels = 0;
        tick();
        chk("rst_fetch_req", {31'd0, fetch_req}, 0);
        chk("rst_credits", {29'd0, credits}, CREDITS);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_coords", {fetch_ty, fetch_tx, fetch_ch}, 0);
        chk("rst_perf", perf_stall_cycles, 0);

        // 1: H=1 W=2 C=2, grant and rvalid held high
        do_reset();
        fetch_gnt = 1; man_rv = 1;
        g0 = cnt_grant; c0 = cnt_cvi; glog.delete();
        start_frame(1, 2, 2);
        wait_done("t1_done", 40);
        chk("t1_grants", cnt_grant - g0, 4);
        chk("t1_cvi_pulses", cnt_cvi - c0, 4);
        chk("t1_credits", {29'd0, credits}, 0);
        if (glog.size() == 4) begin
            chk("t1_p0", glog[0], {8'd0, 8'd0, 10'd0});
            chk("t1_p1", glog[1], {8'd0, 8'd0, 10'd1});
            chk("t1_p2", glog[2], {8'd0, 8'd1, 10'd0});
            chk("t1_p3", glog[3], {8'd0, 8'd1, 10'd1});
        end else chk("t1_log_size", glog.size(), 4);
        fetch_gnt = 0; man_rv = 0;

        // 2: 6-patch frame, credits run out
        do_reset();
        auto_rv = 1; fetch_gnt = 1; g0 = cnt_grant;
        start_frame(1, 3, 2);
        repeat (30) tick();
        chk("t2_grants_stalled", cnt_grant - g0, 4);
        chk("t2_credits_zero", {29'd0, credits}, 0);
        chk("t2_req_low", {31'd0, fetch_req}, 0);
        chk("t2_busy", {31'd0, busy}, 1);
        credit_ret = 1; tick(); credit_ret = 0;
        repeat (4) tick();
        chk("t2_fifth_grant", cnt_grant - g0, 5);
        credit_ret = 1; tick(); credit_ret = 0;
        wait_done("t2_done", 40);
        fetch_gnt = 0; auto_rv = 0;

        // 3: simultaneous grant/return, then overflow
        do_reset();
        auto_rv = 1;
        start_frame(1, 1, 4);
        grant_one(0); grant_one(0);
        chk("t3_credits_2", {29'd0, credits}, 2);
        grant_one(1);
        chk("t3_cred_same_cycle", {29'd0, credits}, 2);
        grant_one(0);
        wait_done("t3_done", 40);
        credit_ret = 1; repeat (3) tick(); credit_ret = 0;
        chk("t3_credits_full", {29'd0, credits}, 4);
        chk("t3_no_err_yet", {31'd0, credit_err}, 0);
        credit_ret = 1; tick(); credit_ret = 0;
        chk("t3_credits_sat", {29'd0, credits}, 4);
        chk("t3_err_set", {31'd0, credit_err}, 1);
        auto_rv = 0;

        // 4: abort while waiting on patch 3 of 8, then a 1-patch frame
        do_reset();
        start_frame(2, 2, 2);
        for (int p = 0; p < 2; p++) begin
            grant_one(0);
            man_rv = 1; tick(); man_rv = 0;
        end
        grant_one(0);
        d0 = cnt_done;
        cfg_abort = 1; tick(); cfg_abort = 0;
        chk("t4_idle_after_abort", {31'd0, busy}, 0);
        chk("t4_req_after_abort", {31'd0, fetch_req}, 0);
        repeat (3) tick();
        chk("t4_no_done", cnt_done - d0, 0);
        auto_rv = 1; fetch_gnt = 1; g0 = cnt_grant; glog.delete();
        start_frame(1, 1, 1);
        wait_done("t4_done", 20);
        chk("t4_one_grant", cnt_grant - g0, 1);
        chk("t4_coord", (glog.size() == 1) ? glog[0] : 32'hFFFF_FFFF, 0);
        fetch_gnt = 0; auto_rv = 0;

        // 5: zero channels
        do_reset();
        g0 = cnt_grant;
        start_frame(2, 2, 0);
        chk("t5_done_pulse", {31'd0, done}, 1);
        chk("t5_busy", {31'd0, busy}, 0);
        tick();
        chk("t5_done_clears", {31'd0, done}, 0);
        repeat (3) tick();
        chk("t5_no_grant", cnt_grant - g0, 0);

        // 6: grant withheld 5 cycles with a stray rvalid
        do_reset();
        man_rv = 1;
        start_frame(1, 1, 2);
        for (int i = 0; i < 5; i++) begin
            chk("t6_req_held", {31'd0, fetch_req}, 1);
            chk("t6_coord_stable", {fetch_ty, fetch_tx, fetch_ch}, 0);
            chk("t6_stray_rvalid", {31'd0, conv_valid_in}, 0);
            tick();
        end
        man_rv = 0; auto_rv = 1; fetch_gnt = 1;
        wait_done("t6_done", 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
